// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver FSM state
// encoding, the frame data width, and the helper that turns a clock
// frequency and line rate into the number of system clocks per bit.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int DATA_BITS = 8;

    // Integer division is intentional: the receiver counts whole clocks per
    // bit, so any fractional remainder shows up as baud-rate error.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always
// visible on rd_data (0 when empty); a pop shows the next entry on the
// same edge.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   wr_en, wr_data  - push request and data; accepted when not full or
//                     when a pop happens in the same cycle
//   rd_en           - pop request, ignored when empty
//   rd_data         - head entry, 0 when empty
//   empty, full     - occupancy flags
//   count           - current occupancy
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_write;
    logic             do_read;

    // A write into a full FIFO is still accepted when the head leaves in
    // the same cycle; a read of an empty FIFO never happens, so a
    // simultaneous push/pop on empty only pushes.
    always_comb begin
        do_read  = rd_en && !empty;
        do_write = wr_en && (!full || rd_en);
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two;
    // count moves only when exactly one of push/pop happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Flags and head data are decoded from the registered count/pointers,
    // so they change on the same edge as the push or pop that caused them.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        rd_data = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Buffered 8N1 UART receiver. rx is synchronised, deframed with mid-bit
// sampling and good bytes are pushed into a FWFT FIFO read by the host.
// Ports:
//   clk, reset   - system clock, asynchronous active-low reset
//   rx           - asynchronous serial input, idle high
//   rd_en        - pop request (ignored when empty)
//   clr_err      - pulse clearing frame_err and overrun
//   rd_data      - FIFO head byte, 0 when empty
//   empty, full  - FIFO occupancy flags
//   count        - FIFO occupancy
//   frame_err    - sticky, a stop bit was sampled low
//   overrun      - sticky, a good byte was dropped because the FIFO was full
//   busy         - receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    uart_rx_state_t       state;
    uart_rx_state_t       state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic [7:0]           shift_reg;
    logic [7:0]           shift_next;
    logic                 push;
    logic                 set_frame;
    logic                 set_overrun;
    logic                 can_accept;

    // Two-flop synchronizer; both stages reset high so reset release never
    // looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register: state, clock-per-bit counter, bit index and
    // the partially assembled byte. Reset discards any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    // A pop in the same cycle frees a slot even when full, so the byte can
    // still be pushed.
    always_comb begin
        can_accept = !full || (rd_en && !empty);
    end

    // Deframing: the start bit is confirmed half a bit in, which lines every
    // later sample up with the middle of its bit. The stop bit is judged at
    // its middle and the FSM goes idle right there, leaving the second half
    // of the stop bit as margin for catching the next start edge.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        push         = 1'b0;
        set_frame    = 1'b0;
        set_overrun  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next   = START;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? IDLE : DATA;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_next = '0;
                    shift_next   = {rx_sync, shift_reg[7:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                    if (rx_sync) begin
                        if (can_accept) begin
                            push = 1'b1;
                        end else begin
                            set_overrun = 1'b1;
                        end
                    end else begin
                        set_frame = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sticky error flags: a new event in the same cycle as clr_err wins so
    // an error is never silently lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (set_frame) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    // Busy follows the registered state, so it rises the cycle after the
    // FSM leaves IDLE and drops the cycle after the stop-bit sample.
    always_comb begin
        busy = (state != IDLE);
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (shift_reg),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed testbench for uart_rx_fifo at the default 50 clocks per bit.
// Frames are driven on the falling clock edge; outputs are sampled on the
// falling edge or 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPB     = 50;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int test_count = 0;
    int fail_count = 0;
    int latency_cycles;

    uart_rx_fifo #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // 50 MHz clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Counts every comparison and reports any mismatch on one line.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one full 8N1 frame, each bit held for CPB clocks, then idles rx.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Counts rising edges from the one that first registers the start bit
    // until empty falls, bounded so a dead receiver cannot hang the run.
    task automatic measureLatency(output int cycles);
        @(negedge clk);
        @(posedge clk);
        cycles = 0;
        while (cycles < LATENCY + CPB) begin
            @(posedge clk);
            cycles++;
            #1;
            if (!empty) break;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic popOne();
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_data"},   32'(rd_data),   32'h0);
        checkOutput({tag, "_empty"},     32'(empty),     32'h1);
        checkOutput({tag, "_full"},      32'(full),      32'h0);
        checkOutput({tag, "_count"},     32'(count),     32'h0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        checkOutput({tag, "_overrun"},   32'(overrun),   32'h0);
        checkOutput({tag, "_busy"},      32'(busy),      32'h0);
    endtask

    initial begin
        logic [7:0] partial_byte;
        logic [7:0] exp_byte;

        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        reset   = 1'b0;
        waitCycles(3);
        checkResetValues("por");
        reset = 1'b1;
        waitCycles(5);

        // Single byte with first-entry latency, then pop back to empty.
        fork
            applyStimulus(8'hA5, 1'b1);
            measureLatency(latency_cycles);
        join
        checkOutput("latency",      32'(latency_cycles), 32'(LATENCY));
        checkOutput("single_empty", 32'(empty),   32'h0);
        checkOutput("single_data",  32'(rd_data), 32'hA5);
        checkOutput("single_count", 32'(count),   32'h1);
        popOne();
        checkOutput("pop_empty", 32'(empty),   32'h1);
        checkOutput("pop_data",  32'(rd_data), 32'h0);
        checkOutput("pop_count", 32'(count),   32'h0);

        // Short low pulse on idle rx must be rejected as a glitch.
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        waitCycles(CPB);
        checkOutput("glitch_busy",  32'(busy),      32'h0);
        checkOutput("glitch_empty", 32'(empty),     32'h1);
        checkOutput("glitch_ferr",  32'(frame_err), 32'h0);
        checkOutput("glitch_ovr",   32'(overrun),   32'h0);
        applyStimulus(8'h3C, 1'b1);
        checkOutput("after_glitch_data",  32'(rd_data), 32'h3C);
        checkOutput("after_glitch_count", 32'(count),   32'h1);
        popOne();

        // Framing error: low stop bit, nothing pushed, then cleared.
        applyStimulus(8'h55, 1'b0);
        waitCycles(2 * CPB);
        checkOutput("ferr_empty", 32'(empty),     32'h1);
        checkOutput("ferr_flag",  32'(frame_err), 32'h1);
        checkOutput("ferr_ovr",   32'(overrun),   32'h0);
        checkOutput("ferr_busy",  32'(busy),      32'h0);
        pulseClear();
        checkOutput("ferr_cleared", 32'(frame_err), 32'h0);

        // Fill with 0x00..0x0F, then a 17th byte overruns.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(i), 1'b1);
            if (i == 15) begin
                checkOutput("fill_full",  32'(full),    32'h1);
                checkOutput("fill_count", 32'(count),   32'h10);
                checkOutput("fill_ovr",   32'(overrun), 32'h0);
            end
        end
        checkOutput("ovr_full",  32'(full),    32'h1);
        checkOutput("ovr_count", 32'(count),   32'h10);
        checkOutput("ovr_flag",  32'(overrun), 32'h1);
        checkOutput("ovr_head",  32'(rd_data), 32'h0);
        pulseClear();
        checkOutput("ovr_cleared", 32'(overrun), 32'h0);

        // Pop exactly on the push edge while full: head 0x00 leaves, 0x77 enters.
        fork
            applyStimulus(8'h77, 1'b1);
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (LATENCY - 1) @(posedge clk);
                @(negedge clk);
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
            end
        join
        checkOutput("pop_push_count", 32'(count),   32'h10);
        checkOutput("pop_push_full",  32'(full),    32'h1);
        checkOutput("pop_push_ovr",   32'(overrun), 32'h0);

        // Drain across the pointer wrap: 0x01..0x0F then 0x77.
        for (int i = 0; i < 16; i++) begin
            exp_byte = (i < 15) ? 8'(i + 1) : 8'h77;
            checkOutput($sformatf("drain_data_%0d", i),  32'(rd_data), 32'(exp_byte));
            checkOutput($sformatf("drain_count_%0d", i), 32'(count),   32'(16 - i));
            popOne();
        end
        checkOutput("drained_empty", 32'(empty),   32'h1);
        checkOutput("drained_count", 32'(count),   32'h0);
        checkOutput("drained_data",  32'(rd_data), 32'h0);

        // Reset mid-frame with a stored byte and a set error flag.
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'h00, 1'b0);
        waitCycles(2 * CPB);
        checkOutput("pre_rst_count", 32'(count),     32'h1);
        checkOutput("pre_rst_ferr",  32'(frame_err), 32'h1);
        partial_byte = 8'hF0;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial_byte[i];
            repeat (CPB) @(negedge clk);
        end
        rx = partial_byte[4];
        repeat (CPB / 2) @(negedge clk);
        checkOutput("mid_frame_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        checkResetValues("mid_rst");
        waitCycles(2);
        reset = 1'b1;
        waitCycles(CPB);
        applyStimulus(8'h81, 1'b1);
        checkOutput("post_rst_data",  32'(rd_data),   32'h81);
        checkOutput("post_rst_count", 32'(count),     32'h1);
        checkOutput("post_rst_ferr",  32'(frame_err), 32'h0);
        checkOutput("post_rst_busy",  32'(busy),      32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
